// File: rtl/bcd_cnt_pkg.sv
// Shared mode encodings and digit-level helpers for the cascaded BCD/radix counter.
// Values are digit-encoded vectors; comparisons are done digit by digit, never on packed binary.
package bcd_cnt_pkg;

  localparam logic [1:0] MODE_SAT      = 2'd0;
  localparam logic [1:0] MODE_WRAP     = 2'd1;
  localparam logic [1:0] MODE_LIM_SAT  = 2'd2;
  localparam logic [1:0] MODE_LIM_WRAP = 2'd3;

  // Widest digit the helpers accept; callers zero-extend narrower digits.
  localparam int unsigned MaxDw = 8;

  typedef logic [MaxDw-1:0] digit_t;

  typedef enum logic [1:0] {
    CmpEq = 2'b00,
    CmpLt = 2'b01,
    CmpGt = 2'b10
  } cmp_e;

  function automatic logic mode_is_lim(logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic mode_is_wrap(logic [1:0] mode);
    return mode[0];
  endfunction

  function automatic cmp_e digit_cmp(digit_t a, digit_t b);
    if (a > b) begin
      return CmpGt;
    end else if (a < b) begin
      return CmpLt;
    end
    return CmpEq;
  endfunction

  // Out-of-range digits are pinned to the largest legal digit.
  function automatic digit_t digit_sat(digit_t d, int unsigned radix);
    if (d >= digit_t'(radix)) begin
      return digit_t'(radix - 1);
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One combinational digit of the cascade: adds or subtracts a small addend (0..2) and
// reports a single carry/borrow to the next digit.
module bcd_digit_cell #(
  parameter int unsigned RADIX = 10,
  parameter int unsigned DW    = 4
) (
  input  logic [DW-1:0] digit_i,
  input  logic [1:0]    add_i,
  input  logic          down_i,
  output logic [DW-1:0] digit_o,
  output logic          cy_o
);

  localparam int unsigned EW = DW + 2;

  logic [EW-1:0] d_ext;
  logic [EW-1:0] a_ext;
  logic [EW-1:0] rad;
  logic [EW-1:0] res;

  // Input digit is always < RADIX, so one carry/borrow is enough for addends up to 2.
  always_comb begin
    d_ext = EW'(digit_i);
    a_ext = EW'(add_i);
    rad   = EW'(RADIX);
    res   = '0;
    cy_o  = 1'b0;
    if (!down_i) begin
      res = d_ext + a_ext;
      if (res >= rad) begin
        res  = res - rad;
        cy_o = 1'b1;
      end
    end else if (d_ext < a_ext) begin
      res  = d_ext + rad - a_ext;
      cy_o = 1'b1;
    end else begin
      res = d_ext - a_ext;
    end
    digit_o = res[DW-1:0];
  end

endmodule

// File: rtl/bcd_cascade_counter.sv
// Multi-digit up/down counter with configurable radix, four overflow modes, load/clear
// and registered carry/borrow pulses for chaining.
module bcd_cascade_counter
  import bcd_cnt_pkg::*;
#(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned RADIX  = 10,
  parameter int unsigned DW     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 carry_in,
  input  logic                 up_down_sel,
  input  logic [1:0]           mode,
  input  logic [DIGITS*DW-1:0] max_val,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  input  logic                 clear,
  output logic [DIGITS*DW-1:0] cnt_out,
  output logic                 carry_out,
  output logic                 borrow_out,
  output logic                 at_zero,
  output logic                 at_max
);

  localparam int unsigned W = DIGITS * DW;

  logic [W-1:0] cnt_q, cnt_d;
  logic         carry_q, carry_d;
  logic         borrow_q, borrow_d;

  logic [1:0]   step;
  logic         lim, wrap;
  logic [W-1:0] all_max, max_sat, load_sat, top;
  logic [W-1:0] raw, top_m1;
  logic [DIGITS-1:0] cy, dcy;
  logic         top_zero;
  logic         cnt_gt_top, raw_gt_top, load_gt_top;
  logic [W-1:0] wrap_up_val, wrap_dn_val;

  assign step = {1'b0, inc} + {1'b0, carry_in};
  assign lim  = mode_is_lim(mode);
  assign wrap = mode_is_wrap(mode);

  // Lexicographic compare from the MSD.
  function automatic logic vec_gt(logic [W-1:0] a, logic [W-1:0] b);
    logic gt;
    logic decided;
    cmp_e c;
    gt      = 1'b0;
    decided = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      c = digit_cmp(digit_t'(a[i*DW +: DW]), digit_t'(b[i*DW +: DW]));
      if (!decided && c != CmpEq) begin
        decided = 1'b1;
        gt      = (c == CmpGt);
      end
    end
    return gt;
  endfunction

  always_comb begin
    all_max  = '0;
    max_sat  = '0;
    load_sat = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      all_max[i*DW +: DW]  = DW'(RADIX - 1);
      max_sat[i*DW +: DW]  = DW'(digit_sat(digit_t'(max_val[i*DW +: DW]), RADIX));
      load_sat[i*DW +: DW] = DW'(digit_sat(digit_t'(load_val[i*DW +: DW]), RADIX));
    end
  end

  assign top = lim ? max_sat : all_max;

  // Two ripple chains: cnt +/- step, and top - 1 for the down-wrap by two.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [1:0] add;
    logic [1:0] dadd;
    if (g == 0) begin : g_lsd
      assign add  = step;
      assign dadd = 2'd1;
    end else begin : g_upper
      assign add  = {1'b0, cy[g-1]};
      assign dadd = {1'b0, dcy[g-1]};
    end

    bcd_digit_cell #(
      .RADIX (RADIX),
      .DW    (DW)
    ) u_cnt_cell (
      .digit_i (cnt_q[g*DW +: DW]),
      .add_i   (add),
      .down_i  (up_down_sel),
      .digit_o (raw[g*DW +: DW]),
      .cy_o    (cy[g])
    );

    bcd_digit_cell #(
      .RADIX (RADIX),
      .DW    (DW)
    ) u_dec_cell (
      .digit_i (top[g*DW +: DW]),
      .add_i   (dadd),
      .down_i  (1'b1),
      .digit_o (top_m1[g*DW +: DW]),
      .cy_o    (dcy[g])
    );
  end

  // top - 1 borrows out of the MSD only when top is zero.
  assign top_zero = dcy[DIGITS-1];

  assign cnt_gt_top  = vec_gt(cnt_q, top);
  assign raw_gt_top  = vec_gt(raw, top);
  assign load_gt_top = vec_gt(load_sat, top);

  // Up-wrap from cnt <= top overshoots by at most one, so the result is 0 or 1;
  // a counter above top (ceiling lowered) restarts at 0.
  always_comb begin
    wrap_up_val = '0;
    if (!cnt_gt_top && cnt_q == top && step == 2'd2 && !top_zero) begin
      wrap_up_val = W'(1);
    end
  end

  // Down-wrap undershoots by one or two.
  always_comb begin
    wrap_dn_val = top;
    if (cnt_q == '0 && step == 2'd2) begin
      wrap_dn_val = top_zero ? '0 : top_m1;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = (lim && load_gt_top) ? top : load_sat;
    end else if (step == 2'd0) begin
      if (lim && cnt_gt_top) begin
        cnt_d = top;
      end
    end else if (!up_down_sel) begin
      if (cy[DIGITS-1] || raw_gt_top) begin
        if (wrap) begin
          cnt_d   = wrap_up_val;
          carry_d = 1'b1;
        end else begin
          cnt_d = top;
        end
      end else begin
        cnt_d = raw;
      end
    end else begin
      if (cy[DIGITS-1]) begin
        if (wrap) begin
          cnt_d    = wrap_dn_val;
          borrow_d = 1'b1;
        end else begin
          cnt_d = '0;
        end
      end else begin
        cnt_d = raw;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign cnt_out    = cnt_q;
  assign carry_out  = carry_q;
  assign borrow_out = borrow_q;
  assign at_zero    = (cnt_q == '0);
  assign at_max     = (cnt_q == top);

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Self-checking bench for bcd_cascade_counter: directed scenarios plus random traffic
// against an integer-valued reference model.
module tb_bcd_cascade_counter;

  localparam int DIGITS = 2;
  localparam int RADIX  = 10;
  localparam int DW     = 4;
  localparam int W      = DIGITS * DW;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         inc, carry_in, up_down_sel, load, clear;
  logic [1:0]   mode;
  logic [W-1:0] max_val, load_val;
  logic [W-1:0] cnt_out;
  logic         carry_out, borrow_out, at_zero, at_max;

  int total = 0;
  int bad   = 0;

  int m_cnt    = 0;
  bit m_carry  = 1'b0;
  bit m_borrow = 1'b0;

  always #5 clk = ~clk;

  bcd_cascade_counter #(
    .DIGITS (DIGITS),
    .RADIX  (RADIX),
    .DW     (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc         (inc),
    .carry_in    (carry_in),
    .up_down_sel (up_down_sel),
    .mode        (mode),
    .max_val     (max_val),
    .load        (load),
    .load_val    (load_val),
    .clear       (clear),
    .cnt_out     (cnt_out),
    .carry_out   (carry_out),
    .borrow_out  (borrow_out),
    .at_zero     (at_zero),
    .at_max      (at_max)
  );

  // Integer value of a digit vector with out-of-range digits read as RADIX-1.
  function automatic int val_sat(logic [W-1:0] v);
    int r  = 0;
    int pw = 1;
    int d;
    for (int i = 0; i < DIGITS; i++) begin
      d  = int'(v[i*DW +: DW]);
      if (d > RADIX - 1) d = RADIX - 1;
      r  = r + d * pw;
      pw = pw * RADIX;
    end
    return r;
  endfunction

  function automatic int top_val(logic [1:0] md, logic [W-1:0] mx);
    if (md[1]) return val_sat(mx);
    return (RADIX ** DIGITS) - 1;
  endfunction

  function automatic logic [W-1:0] enc(int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*DW +: DW] = DW'(x % RADIX);
      x = x / RADIX;
    end
    return r;
  endfunction

  // Next state straight from the arithmetic rules, using the inputs of the edge just taken.
  task automatic model_update();
    int  st, top, m, n, nc;
    bit  c, b, lim, wr;
    st  = int'(inc) + int'(carry_in);
    top = top_val(mode, max_val);
    m   = top + 1;
    lim = mode[1];
    wr  = mode[0];
    nc  = m_cnt;
    c   = 1'b0;
    b   = 1'b0;
    if (clear) begin
      nc = 0;
    end else if (load) begin
      nc = val_sat(load_val);
      if (lim && nc > top) nc = top;
    end else if (st == 0) begin
      if (lim && m_cnt > top) nc = top;
    end else if (!up_down_sel) begin
      n = m_cnt + st;
      if (n > top) begin
        if (wr) begin
          nc = (m_cnt > top) ? 0 : (n - m) % m;
          c  = 1'b1;
        end else begin
          nc = top;
        end
      end else begin
        nc = n;
      end
    end else begin
      n = m_cnt - st;
      if (n < 0) begin
        if (wr) begin
          nc = ((n % m) + m) % m;
          b  = 1'b1;
        end else begin
          nc = 0;
        end
      end else begin
        nc = n;
      end
    end
    m_cnt    = nc;
    m_carry  = c;
    m_borrow = b;
  endtask

  task automatic run_cycle();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic idle_inputs();
    inc = 1'b0; carry_in = 1'b0; load = 1'b0; clear = 1'b0; up_down_sel = 1'b0;
  endtask

  task automatic do_load(logic [W-1:0] v);
    idle_inputs();
    load = 1'b1; load_val = v;
    run_cycle();
    load = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    mode = 2'd1; max_val = '0; load_val = '0; rst_n = 1'b0;
    #15;
    total++;
    if (cnt_out !== '0 || carry_out !== 1'b0 || borrow_out !== 1'b0 || at_zero !== 1'b1) begin
      bad++;
      $display("FAIL reset_init got cnt=%h c=%b b=%b z=%b exp cnt=00 c=0 b=0 z=1",
               cnt_out, carry_out, borrow_out, at_zero);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    do_load(8'h37);
    inc = 1'b1;
    run_cycle();
    total++;
    if (cnt_out !== enc(m_cnt)) begin
      bad++; $display("FAIL count_38 got=%h exp=%h", cnt_out, enc(m_cnt));
    end
    inc = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    m_cnt = 0; m_carry = 1'b0; m_borrow = 1'b0;
    total++;
    if (cnt_out !== '0 || carry_out !== 1'b0 || borrow_out !== 1'b0 || at_zero !== 1'b1) begin
      bad++;
      $display("FAIL reset_async got cnt=%h c=%b b=%b z=%b exp cnt=00 c=0 b=0 z=1",
               cnt_out, carry_out, borrow_out, at_zero);
    end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_wrap_up();
    mode = 2'd1;
    do_load(8'h97);
    inc = 1'b1; carry_in = 1'b1;
    run_cycle();
    total++;
    if (cnt_out !== 8'h99 || carry_out !== 1'b0 || at_max !== 1'b1) begin
      bad++; $display("FAIL wrap_97_99 got=%h c=%b max=%b exp=99 c=0 max=1", cnt_out, carry_out, at_max);
    end
    run_cycle();
    total++;
    if (cnt_out !== 8'h01 || carry_out !== 1'b1) begin
      bad++; $display("FAIL wrap_99_01 got=%h c=%b exp=01 c=1", cnt_out, carry_out);
    end
    idle_inputs();
    run_cycle();
    total++;
    if (carry_out !== 1'b0 || cnt_out !== 8'h01) begin
      bad++; $display("FAIL wrap_pulse_end got=%h c=%b exp=01 c=0", cnt_out, carry_out);
    end
  endtask

  task automatic test_sat();
    mode = 2'd0;
    do_load(8'h98);
    inc = 1'b1; carry_in = 1'b1;
    run_cycle();
    total++;
    if (cnt_out !== 8'h99 || at_max !== 1'b1 || carry_out !== 1'b0) begin
      bad++; $display("FAIL sat_98_99 got=%h max=%b c=%b exp=99 max=1 c=0", cnt_out, at_max, carry_out);
    end
    run_cycle();
    total++;
    if (cnt_out !== 8'h99 || carry_out !== 1'b0) begin
      bad++; $display("FAIL sat_hold got=%h c=%b exp=99 c=0", cnt_out, carry_out);
    end
    do_load(8'h01);
    inc = 1'b1; carry_in = 1'b1; up_down_sel = 1'b1;
    run_cycle();
    total++;
    if (cnt_out !== 8'h00 || borrow_out !== 1'b0 || at_zero !== 1'b1) begin
      bad++; $display("FAIL sat_floor got=%h b=%b z=%b exp=00 b=0 z=1", cnt_out, borrow_out, at_zero);
    end
    idle_inputs();
  endtask

  task automatic test_lim_wrap();
    mode = 2'd3; max_val = 8'h06;
    do_load(8'h05);
    inc = 1'b1; carry_in = 1'b1;
    run_cycle();
    total++;
    if (cnt_out !== 8'h00 || carry_out !== 1'b1) begin
      bad++; $display("FAIL limwrap_up got=%h c=%b exp=00 c=1", cnt_out, carry_out);
    end
    carry_in = 1'b0; up_down_sel = 1'b1;
    run_cycle();
    total++;
    if (cnt_out !== 8'h06 || borrow_out !== 1'b1 || carry_out !== 1'b0 || at_max !== 1'b1) begin
      bad++; $display("FAIL limwrap_down got=%h b=%b c=%b max=%b exp=06 b=1 c=0 max=1",
                      cnt_out, borrow_out, carry_out, at_max);
    end
    idle_inputs();
  endtask

  task automatic test_lim_sat_clamp();
    mode = 2'd2; max_val = 8'h99;
    do_load(8'h09);
    max_val = 8'h04;
    run_cycle();
    total++;
    if (cnt_out !== 8'h04 || carry_out !== 1'b0 || borrow_out !== 1'b0) begin
      bad++; $display("FAIL clamp_lowered got=%h c=%b b=%b exp=04 c=0 b=0", cnt_out, carry_out, borrow_out);
    end
    do_load(8'h08);
    total++;
    if (cnt_out !== 8'h04) begin
      bad++; $display("FAIL clamp_load got=%h exp=04", cnt_out);
    end
  endtask

  task automatic test_priority();
    mode = 2'd1; max_val = '0;
    do_load(8'h55);
    clear = 1'b1; load = 1'b1; load_val = 8'h22; inc = 1'b1;
    run_cycle();
    total++;
    if (cnt_out !== 8'h00 || carry_out !== 1'b0 || borrow_out !== 1'b0) begin
      bad++; $display("FAIL prio_clear got=%h c=%b b=%b exp=00 c=0 b=0", cnt_out, carry_out, borrow_out);
    end
    do_load(8'h99);
    load = 1'b1; load_val = 8'h11; inc = 1'b1; carry_in = 1'b1;
    run_cycle();
    total++;
    if (cnt_out !== 8'h11 || carry_out !== 1'b0) begin
      bad++; $display("FAIL prio_load got=%h c=%b exp=11 c=0", cnt_out, carry_out);
    end
    do_load(8'hC3);
    total++;
    if (cnt_out !== 8'h93) begin
      bad++; $display("FAIL load_digit_sat got=%h exp=93", cnt_out);
    end
  endtask

  task automatic test_back_to_back();
    mode = 2'd3; max_val = 8'h00;
    do_load(8'h00);
    inc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      total++;
      if (carry_out !== 1'b1 || cnt_out !== 8'h00) begin
        bad++; $display("FAIL b2b_carry[%0d] got=%h c=%b exp=00 c=1", i, cnt_out, carry_out);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [W-1:0] exp_cnt;
    bit exp_max;
    for (int i = 0; i < 400; i++) begin
      if (i % 8 == 0) begin
        mode    = 2'($urandom_range(0, 3));
        max_val = W'($urandom);
        up_down_sel = 1'($urandom);
      end
      inc      = 1'($urandom);
      carry_in = 1'($urandom);
      load     = ($urandom_range(0, 15) == 0);
      clear    = ($urandom_range(0, 31) == 0);
      load_val = W'($urandom);
      run_cycle();
      exp_cnt = enc(m_cnt);
      exp_max = (m_cnt == top_val(mode, max_val));
      total++;
      if (cnt_out !== exp_cnt || carry_out !== m_carry || borrow_out !== m_borrow ||
          at_zero !== (m_cnt == 0) || at_max !== exp_max || (carry_out && borrow_out)) begin
        bad++;
        $display("FAIL rand[%0d] got cnt=%h c=%b b=%b z=%b m=%b exp cnt=%h c=%b b=%b z=%b m=%b",
                 i, cnt_out, carry_out, borrow_out, at_zero, at_max,
                 exp_cnt, m_carry, m_borrow, (m_cnt == 0), exp_max);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_sat();
    test_lim_wrap();
    test_lim_sat_clamp();
    test_priority();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
